// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// one bit per clock, with a registered result and a one-cycle done pulse.

module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] op_a, op_b, psum, psum_n;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s, c, last;

  serial_adder_fa u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  // new bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  assign psum_n = WIDTH'({s, psum} >> 1);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (last)  state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          psum  <= psum_n;
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum  <= psum_n;
            cout <= c;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 functional/latency/reset cases
// and an exhaustive sweep of a WIDTH=2 instance.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin, busy, done, cout;
  logic [7:0] a, b, sum;

  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full WIDTH=8 operation: latency, busy length, result, return to idle
  task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xc, input logic [7:0] es, input logic ec);
    int cyc, bcnt;
    start = 1'b1; a = xa; b = xb; cin = xc;
    tick();
    start = 1'b0; a = ~xa; b = ~xb; cin = ~xc;
    cyc = 0;
    bcnt = int'(busy);
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      bcnt += int'(busy);
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd8);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd9);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dcnt, cyc;
    logic [2:0] exp3;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("opffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("op0001", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // start held high, operands changing every cycle: accepts at t=0 and t=10
    dcnt = 0;
    start = 1'b1; cin = 1'b0;
    for (int t = 0; t < 20; t++) begin
      a = 8'(t * 17 + 3);
      b = 8'(t * 29 + 5);
      tick();
      dcnt += int'(done);
      if (t == 8) begin
        chk("held_done0", 64'(done), 64'd1);
        chk("held_sum0", 64'(sum), 64'h08);
      end
      if (t == 13) chk("held_sum_stable", 64'(sum), 64'h08);
      if (t == 18) begin
        chk("held_done1", 64'(done), 64'd1);
        chk("held_sum1", 64'(sum), 64'hD4);
        chk("held_cout1", 64'(cout), 64'd0);
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(dcnt), 64'd2);
    tick();
    tick();

    // reset during RUN aborts with no done pulse
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dcnt = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      dcnt += int'(done) + int'(busy);
    end
    chk("abort_quiet", 64'(dcnt), 64'd0);
    run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // exhaustive WIDTH=2
    for (int i = 0; i < 32; i++) begin
      a2 = 2'(i >> 3); b2 = 2'(i >> 1); cin2 = i[0];
      exp3 = 3'(a2) + 3'(b2) + 3'(cin2);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 20) begin
        tick();
        cyc++;
      end
      chk($sformatf("w2_%0d_%0d_%0d", a2, b2, cin2), 64'({cout2, sum2}), 64'(exp3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
